// File: rtl/translayer_pkg.sv
// Shared definitions for the egress transaction layer: default sizes, the
// supervisory FSM encoding and the threshold clamp helper.
package translayer_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Thresholds above the FIFO depth saturate; an almost-full threshold of 0
  // would stall the arbiter forever, so it means "full depth" instead.
  function automatic logic [7:0] clamp_thresh(input logic [7:0] val,
                                              input logic       zero_is_depth,
                                              input logic [7:0] depth);
    logic [7:0] res;
    res = val;
    if (zero_is_depth && (val == 8'd0)) res = depth;
    else if (val > depth)               res = depth;
    return res;
  endfunction

endpackage

// File: rtl/translayer_merge_fifo.sv
// Output FIFO of the merge stage: one write port fed by the lane arbiter,
// registered read port, and a pulse when a push hits a full FIFO.
module fifo_merge_out #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full_err
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
  assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
      end
      // An underflowing pop leaves the read port exactly as it was.
      if (!(i_pop && (r_count == '0))) r_rd_valid <= w_pop_ok;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_count    = r_count;
  assign o_full_err = i_push && !w_push_ok;

endmodule

// File: rtl/translayer_merge.sv
// Egress merge: round-robin drains two lane FIFOs into one output FIFO under
// the init/idle/active/error supervisory FSM with programmable thresholds.
module translayer_merge
  import translayer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [7:0]        UMF,
  input  logic [7:0]        UME,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              empty_0,
  output logic              pop_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              empty_1,
  output logic              pop_1,
  input  logic              pop_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty_out,
  output logic              almost_full_out,
  output logic              almost_empty_out,
  output logic              error_out,
  output logic              active_out,
  output logic              idle_out,
  output logic [2:0]        state_out,
  output logic [ADDR_W:0]   count_out
);

  state_t            r_state;
  logic [ADDR_W:0]   r_umf;
  logic [ADDR_W:0]   r_ume;
  logic              r_rr;
  logic              r_inflight;
  logic              r_inflight_lane;
  logic [ADDR_W:0]   w_count;
  logic              w_full_err;
  logic              w_gate;
  logic              w_arb_en;
  logic              w_grant_0;
  logic              w_grant_1;
  logic [DATA_W-1:0] w_push_data;
  logic              w_err;

  // The word already requested from a lane counts against the threshold.
  assign w_gate    = ({1'b0, w_count} + {{(ADDR_W+1){1'b0}}, r_inflight}) < {1'b0, r_umf};
  assign w_arb_en  = (r_state == ST_ACTIVE) && w_gate;
  assign w_grant_0 = w_arb_en && !empty_0 && (empty_1 || !r_rr);
  assign w_grant_1 = w_arb_en && !empty_1 && (empty_0 || r_rr);
  assign pop_0     = w_grant_0;
  assign pop_1     = w_grant_1;

  assign w_push_data = r_inflight_lane ? data_in_1 : data_in_0;
  assign w_err       = (r_state != ST_RESET) &&
                       ((pop_out && (w_count == '0)) || w_full_err);

  fifo_merge_out #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (pop_out),
    .o_rd_data   (data_out),
    .o_rd_valid  (valid_out),
    .o_count     (w_count),
    .o_full_err  (w_full_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_RESET;
      r_umf           <= (ADDR_W+1)'(DEPTH);
      r_ume           <= '0;
      r_rr            <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_lane <= 1'b0;
    end else begin
      r_inflight      <= w_grant_0 | w_grant_1;
      r_inflight_lane <= w_grant_1;
      // r_rr names the lane preferred next: the one not just served.
      if (w_grant_0 | w_grant_1) r_rr <= w_grant_0;
      if (w_err) begin
        r_state <= ST_ERROR;
      end else begin
        case (r_state)
          ST_RESET: r_state <= ST_INIT;
          ST_INIT: begin
            r_umf <= (ADDR_W+1)'(clamp_thresh(UMF, 1'b1, 8'(DEPTH)));
            r_ume <= (ADDR_W+1)'(clamp_thresh(UME, 1'b0, 8'(DEPTH)));
            if (!init) r_state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (init)                     r_state <= ST_INIT;
            else if (!empty_0 || !empty_1) r_state <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (empty_0 && empty_1 && !r_inflight && (w_count == '0)) r_state <= ST_IDLE;
          end
          ST_ERROR: r_state <= ST_ERROR;
          default:  r_state <= ST_RESET;
        endcase
      end
    end
  end

  assign empty_out        = (w_count == '0);
  assign almost_full_out  = (w_count >= r_umf);
  assign almost_empty_out = (w_count <= r_ume);
  assign error_out        = (r_state == ST_ERROR);
  assign active_out       = (r_state == ST_ACTIVE);
  assign idle_out         = (r_state == ST_IDLE);
  assign state_out        = r_state;
  assign count_out        = w_count;

endmodule

// File: tb/tb_translayer_merge.sv
// Directed bench for translayer_merge: behavioural lane FIFOs feed the DUT,
// expected output words are queued at load time and popped on each read.
module tb_translayer_merge;
  import translayer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, init, pop_out;
  logic [7:0] UMF, UME;
  logic [5:0] data_in_0 = '0, data_in_1 = '0;
  logic       empty_0 = 1'b1, empty_1 = 1'b1;
  logic       pop_0, pop_1;
  logic [5:0] data_out;
  logic       valid_out, empty_out, almost_full_out, almost_empty_out;
  logic       error_out, active_out, idle_out;
  logic [2:0] state_out;
  logic [3:0] count_out;

  logic [5:0] lane0_q[$], lane1_q[$];
  logic [5:0] exp_q[$];
  bit         pop_log[$];
  int         lane0_pops = 0, lane1_pops = 0, bad_pops = 0;
  int         n_chk = 0, n_pass = 0, n_fail = 0;
  int         base;
  bit         rr_exp[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  translayer_merge dut (
    .clk(clk), .reset(reset), .init(init), .UMF(UMF), .UME(UME),
    .data_in_0(data_in_0), .empty_0(empty_0), .pop_0(pop_0),
    .data_in_1(data_in_1), .empty_1(empty_1), .pop_1(pop_1),
    .pop_out(pop_out), .data_out(data_out), .valid_out(valid_out),
    .empty_out(empty_out), .almost_full_out(almost_full_out),
    .almost_empty_out(almost_empty_out), .error_out(error_out),
    .active_out(active_out), .idle_out(idle_out),
    .state_out(state_out), .count_out(count_out)
  );

  // Lane FIFO models: read data appears the cycle after a pop.
  always @(posedge clk) begin
    if (pop_0 && pop_1) bad_pops <= bad_pops + 1;
    if (pop_0) begin
      if (lane0_q.size() > 0) data_in_0 <= lane0_q.pop_front();
      else bad_pops <= bad_pops + 1;
      pop_log.push_back(1'b0);
      lane0_pops <= lane0_pops + 1;
    end
    if (pop_1) begin
      if (lane1_q.size() > 0) data_in_1 <= lane1_q.pop_front();
      else bad_pops <= bad_pops + 1;
      pop_log.push_back(1'b1);
      lane1_pops <= lane1_pops + 1;
    end
    empty_0 <= (lane0_q.size() == 0);
    empty_1 <= (lane1_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_thresh(input logic [7:0] umf, input logic [7:0] ume);
    UMF = umf; UME = ume; init = 1'b1;
    tick(2);
    init = 1'b0;
    tick(2);
  endtask

  // Back-to-back reads of n words; each one compared against the queue head.
  task automatic read_words(input int n);
    logic [5:0] e;
    pop_out = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == n - 1) pop_out = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bx;
      check("rd_valid", valid_out, 1'b1);
      check("rd_data", data_out, e);
    end
  endtask

  task automatic wait_pop(input int lane, input string tag);
    int k;
    for (k = 0; k < 30; k++) begin
      if ((lane == 0) ? pop_0 : pop_1) break;
      tick();
    end
    check(tag, (k < 30), 1'b1);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; UMF = 8'd6; UME = 8'd2; pop_out = 1'b0;
    tick(3);
    check("rst_state", state_out, ST_RESET);
    check("rst_empty", empty_out, 1'b1);
    check("rst_aempty", almost_empty_out, 1'b1);
    check("rst_afull", almost_full_out, 1'b0);
    check("rst_error", error_out, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_idle_active", {idle_out, active_out}, 2'b00);
    check("rst_pops", {pop_0, pop_1}, 2'b00);
    check("rst_count", count_out, 4'd0);
    check("rst_data", data_out, 6'd0);

    reset = 1'b0; init = 1'b1;
    tick(3);
    check("init_state", state_out, ST_INIT);
    init = 1'b0;
    tick(2);
    check("init_idle", idle_out, 1'b1);
    check("init_empty", empty_out, 1'b1);
    check("init_aempty", almost_empty_out, 1'b1);
    check("init_error", error_out, 1'b0);

    // Round robin across both lanes with latency probe
    lane0_q.push_back(6'h11); lane0_q.push_back(6'h12);
    lane1_q.push_back(6'h21); lane1_q.push_back(6'h22);
    exp_q.push_back(6'h11); exp_q.push_back(6'h21);
    exp_q.push_back(6'h12); exp_q.push_back(6'h22);
    wait_pop(0, "rr_first_pop");
    check("rr_first_single", pop_1, 1'b0);
    tick();
    check("lat_1cyc_empty", empty_out, 1'b1);
    tick();
    check("lat_2cyc_avail", empty_out, 1'b0);
    tick(6);
    check("rr_count", count_out, 4'd4);
    check("rr_aempty", almost_empty_out, 1'b0);
    check("rr_afull", almost_full_out, 1'b0);
    check("rr_npops", pop_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < pop_log.size()) check("rr_order", pop_log[i], rr_exp[i]);
    read_words(4);
    tick(3);
    check("rr_back_idle", idle_out, 1'b1);
    check("rr_back_empty", empty_out, 1'b1);

    // Almost-full threshold throttles lane pops
    set_thresh(8'd4, 8'd1);
    base = lane0_pops;
    for (int i = 1; i <= 10; i++) begin
      lane0_q.push_back(6'(i)); exp_q.push_back(6'(i));
    end
    tick(20);
    check("umf_afull", almost_full_out, 1'b1);
    check("umf_count", count_out, 4'd4);
    check("umf_npops", lane0_pops - base, 4);
    tick(4);
    check("umf_hold", lane0_pops - base, 4);
    read_words(1);
    tick(6);
    check("umf_one_more", lane0_pops - base, 5);
    check("umf_refill", count_out, 4'd4);
    for (int i = 0; i < 9; i++) begin
      read_words(1);
      tick(3);
    end
    check("umf_drain_idle", idle_out, 1'b1);
    check("umf_drain_empty", empty_out, 1'b1);

    // Streaming reads every cycle across pointer wrap
    set_thresh(8'd5, 8'd2);
    for (int i = 0; i < 20; i++) begin
      lane0_q.push_back(6'(40 + i)); exp_q.push_back(6'(40 + i));
    end
    tick(20);
    check("strm_fill", count_out, 4'd5);
    pop_out = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [5:0] e;
      tick();
      if (i == 11) pop_out = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bx;
      check("strm_valid", valid_out, 1'b1);
      check("strm_data", data_out, e);
      if (i >= 1) check("strm_count", count_out, 4'd3);
    end
    check("strm_noerr", error_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      read_words(1);
      tick(3);
    end
    tick(3);
    check("strm_idle", idle_out, 1'b1);
    check("strm_exp_left", exp_q.size(), 0);

    // Underflow read is a sticky error that halts lane pops
    pop_out = 1'b1;
    tick();
    pop_out = 1'b0;
    check("err_flag", error_out, 1'b1);
    check("err_state", state_out, ST_ERROR);
    check("err_valid", valid_out, 1'b0);
    check("err_count", count_out, 4'd0);
    check("err_not_idle", idle_out, 1'b0);
    base = lane0_pops;
    lane0_q.push_back(6'h3a); lane0_q.push_back(6'h3b);
    tick(8);
    check("err_no_pops", lane0_pops - base, 0);
    check("err_sticky", error_out, 1'b1);
    lane0_q.delete();
    tick(2);

    // Reset with a lane word in flight
    reset = 1'b1;
    tick(2);
    check("rs_err_clear", error_out, 1'b0);
    reset = 1'b0;
    set_thresh(8'd6, 8'd2);
    lane1_q.push_back(6'h2a);
    wait_pop(1, "rs_pop1");
    tick();
    reset = 1'b1;
    tick();
    check("rs_state", state_out, ST_RESET);
    check("rs_count", count_out, 4'd0);
    reset = 1'b0;
    tick(4);
    check("rs_nostore", count_out, 4'd0);
    check("rs_empty", empty_out, 1'b1);
    check("rs_idle", idle_out, 1'b1);
    check("lane_protocol", bad_pops, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
